// File: rtl/consec_run_detect_if.sv
// consec_run_detect_if: bundles the sample stream, its configuration and the run
// status outputs of consec_run_detect.
//   master modport: drives clr, in_valid, in, thresh, mode; observes the status.
//   slave modport : the detector; consumes the stream, drives hit, hit_pulse,
//                   run_bit, run_cnt, max_len.
// Parameter CNT_W sets the width of thresh, run_cnt and max_len.
interface consec_run_detect_if #(
    parameter int unsigned CNT_W = 4
) ();
    logic             clr;
    logic             in_valid;
    logic             in;
    logic [CNT_W-1:0] thresh;
    logic [1:0]       mode;
    logic             hit;
    logic             hit_pulse;
    logic             run_bit;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] max_len;

    modport master (
        output clr, in_valid, in, thresh, mode,
        input  hit, hit_pulse, run_bit, run_cnt, max_len
    );

    modport slave (
        input  clr, in_valid, in, thresh, mode,
        output hit, hit_pulse, run_bit, run_cnt, max_len
    );
endinterface

// File: rtl/consec_run_detect.sv
// consec_run_detect: tracks the length of the current run of identical serial
// bits and flags when it reaches a runtime-programmable threshold.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - consec_run_detect_if.slave:
//              clr       synchronous clear (priority over in_valid)
//              in_valid  qualifies in
//              in        serial data bit
//              thresh    run length for detection, 0 disables detection
//              mode      00 ones/zeros, 01 ones, 10 zeros, 11 detection off
//              hit       current run meets threshold and polarity
//              hit_pulse one-cycle pulse when the run first reaches thresh
//              run_bit   value of the current run
//              run_cnt   saturating length of the current run
//              max_len   longest run since reset/clr
// Build option: define CONSEC_RUN_MAXLEN_EN to enable max_len tracking;
// otherwise max_len is tied to 0.
module consec_run_detect #(
    parameter int unsigned CNT_W = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    consec_run_detect_if.slave   bus
);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q;
    logic             run_bit_q;
    logic [CNT_W-1:0] run_cnt_q;
    logic             hit_q;
    logic             hit_pulse_q;

    logic             accept;
    logic             restart;
    logic             next_bit;
    logic [CNT_W-1:0] next_cnt;
    logic             pol_match;
    logic             thr_on;
    logic             hit_d;
    logic             hit_pulse_d;

    assign accept = bus.in_valid && !bus.clr;

    // Next run state and detection flags, evaluated as if the sample is accepted.
    always_comb begin
        restart  = 1'b1;
        next_bit = bus.in;
        next_cnt = CntOne;
        if (state_q == StRun && bus.in == run_bit_q) begin
            restart  = 1'b0;
            next_bit = run_bit_q;
            next_cnt = (run_cnt_q == CntMax) ? run_cnt_q : run_cnt_q + CntOne;
        end

        unique case (bus.mode)
            2'b00:   pol_match = 1'b1;
            2'b01:   pol_match = next_bit;
            2'b10:   pol_match = !next_bit;
            default: pol_match = 1'b0;
        endcase

        thr_on      = (bus.thresh != '0);
        hit_d       = thr_on && pol_match && (next_cnt >= bus.thresh);
        // A saturated run sitting at thresh must not re-fire.
        hit_pulse_d = thr_on && pol_match && (next_cnt == bus.thresh) &&
                      (restart || run_cnt_q != bus.thresh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            run_bit_q   <= 1'b0;
            run_cnt_q   <= '0;
            hit_q       <= 1'b0;
            hit_pulse_q <= 1'b0;
        end else if (bus.clr) begin
            state_q     <= StIdle;
            run_bit_q   <= 1'b0;
            run_cnt_q   <= '0;
            hit_q       <= 1'b0;
            hit_pulse_q <= 1'b0;
        end else begin
            hit_pulse_q <= 1'b0;
            if (accept) begin
                state_q     <= StRun;
                run_bit_q   <= next_bit;
                run_cnt_q   <= next_cnt;
                hit_q       <= hit_d;
                hit_pulse_q <= hit_pulse_d;
            end
        end
    end

    assign bus.hit       = hit_q;
    assign bus.hit_pulse = hit_pulse_q;
    assign bus.run_bit   = run_bit_q;
    assign bus.run_cnt   = run_cnt_q;

`ifdef CONSEC_RUN_MAXLEN_EN
    logic [CNT_W-1:0] max_len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_len_q <= '0;
        end else if (bus.clr) begin
            max_len_q <= '0;
        end else if (accept && next_cnt > max_len_q) begin
            max_len_q <= next_cnt;
        end
    end

    assign bus.max_len = max_len_q;
`else
    assign bus.max_len = '0;
`endif

endmodule

// File: tb/tb_consec_run_detect.sv
// tb_consec_run_detect: table-driven vectors for the basic run/threshold
// sequences, hand-written multi-cycle corner cases (gaps, saturation, clear,
// asynchronous reset, longest run) and a randomized stream checked against a
// history-based reference model.
module tb_consec_run_detect;
    localparam int unsigned CNT_W = 4;
    localparam int SatMax = 15;

    logic clk;
    logic rst_n;

    consec_run_detect_if #(.CNT_W(CNT_W)) bus ();

    consec_run_detect #(.CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: history of accepted bits since reset/clr.
    bit hist[$];
    int m_hit, m_pulse, m_bit, m_cnt, m_max;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int trailing_len();
        int n = 0;
        if (hist.size() == 0) return 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size() - 1] || n == SatMax) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_hit = 0; m_pulse = 0; m_bit = 0; m_cnt = 0; m_max = 0;
    endtask

    task automatic model_step(input bit c, input bit v, input bit b,
                              input int th, input int md);
        bit restart;
        bit pol;
        int prev;
        int nc;
        if (c) begin
            model_reset();
            return;
        end
        m_pulse = 0;
        if (!v) return;
        restart = (hist.size() == 0) || (hist[hist.size() - 1] != b);
        prev    = restart ? 0 : trailing_len();
        hist.push_back(b);
        if (hist.size() > 40) void'(hist.pop_front());
        nc = trailing_len();
        case (md)
            0: pol = 1;
            1: pol = (b == 1);
            2: pol = (b == 0);
            default: pol = 0;
        endcase
        m_hit   = (th != 0 && pol && nc >= th) ? 1 : 0;
        m_pulse = (th != 0 && pol && nc == th && (restart || prev != th)) ? 1 : 0;
        m_bit   = b;
        m_cnt   = nc;
        if (nc > m_max) m_max = nc;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".hit"}, int'(bus.hit), m_hit);
        chk({tag, ".hit_pulse"}, int'(bus.hit_pulse), m_pulse);
        chk({tag, ".run_bit"}, int'(bus.run_bit), m_bit);
        chk({tag, ".run_cnt"}, int'(bus.run_cnt), m_cnt);
`ifdef CONSEC_RUN_MAXLEN_EN
        chk({tag, ".max_len"}, int'(bus.max_len), m_max);
`else
        chk({tag, ".max_len"}, int'(bus.max_len), 0);
`endif
    endtask

    // Drive one cycle, advance the model on the edge, compare 1ns later.
    task automatic step(input bit c, input bit v, input bit b, input int th, input int md,
                        input string tag);
        bus.clr      = c;
        bus.in_valid = v;
        bus.in       = b;
        bus.thresh   = th[CNT_W-1:0];
        bus.mode     = md[1:0];
        @(posedge clk);
        model_step(c, v, b, th, md);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit       c;
        bit       v;
        bit       b;
        int       th;
        int       md;
        int       e_hit;
        int       e_pulse;
        int       e_cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int pulses;
        // Test-plan sequence 1: thresh=4, mode 00, 1,1,1,1,0,0,0,0.
        vecs.push_back('{1, 0, 0, 4, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 4, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 1, 4, 0, 0, 0, 2});
        vecs.push_back('{0, 1, 1, 4, 0, 0, 0, 3});
        vecs.push_back('{0, 1, 1, 4, 0, 1, 1, 4});
        vecs.push_back('{0, 1, 0, 4, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 4, 0, 0, 0, 2});
        vecs.push_back('{0, 1, 0, 4, 0, 0, 0, 3});
        vecs.push_back('{0, 1, 0, 4, 0, 1, 1, 4});
        // Test-plan sequence 2: thresh=3, mode 01, 0,0,0,0,1,1,1.
        vecs.push_back('{1, 0, 0, 3, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 3, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 3, 1, 0, 0, 2});
        vecs.push_back('{0, 1, 0, 3, 1, 0, 0, 3});
        vecs.push_back('{0, 1, 0, 3, 1, 0, 0, 4});
        vecs.push_back('{0, 1, 1, 3, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 1, 3, 1, 0, 0, 2});
        vecs.push_back('{0, 1, 1, 3, 1, 1, 1, 3});

        bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in = 1'b0;
        bus.thresh = '0; bus.mode = 2'b00;
        model_reset();
        rst_n = 1'b0;
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c, vecs[i].v, vecs[i].b, vecs[i].th, vecs[i].md, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_hit", i), int'(bus.hit), vecs[i].e_hit);
            chk($sformatf("vec%0d.tbl_pulse", i), int'(bus.hit_pulse), vecs[i].e_pulse);
            chk($sformatf("vec%0d.tbl_cnt", i), int'(bus.run_cnt), vecs[i].e_cnt);
        end

        // Invalid cycles hold the run.
        step(1, 0, 0, 3, 0, "gap.clr");
        step(0, 1, 1, 3, 0, "gap.a1");
        step(0, 1, 1, 3, 0, "gap.a2");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, i[0], 3, 0, "gap.idle");
            chk("gap.hold_cnt", int'(bus.run_cnt), 2);
            chk("gap.hold_hit", int'(bus.hit), 0);
        end
        step(0, 1, 1, 3, 0, "gap.a3");
        chk("gap.hit", int'(bus.hit), 1);
        chk("gap.pulse", int'(bus.hit_pulse), 1);

        // Saturation at 15 with thresh=15: one pulse, hit held.
        step(1, 0, 0, 15, 0, "sat.clr");
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 15, 0, "sat");
            if (bus.hit_pulse) pulses++;
        end
        chk("sat.pulses", pulses, 1);
        chk("sat.cnt", int'(bus.run_cnt), 15);
        chk("sat.hit", int'(bus.hit), 1);

        // clr with in_valid discards the sample.
        step(1, 0, 0, 3, 0, "clr.pre");
        for (int i = 0; i < 5; i++) step(0, 1, 1, 3, 0, "clr.run");
        chk("clr.cnt5", int'(bus.run_cnt), 5);
        chk("clr.hit5", int'(bus.hit), 1);
        step(1, 1, 1, 3, 0, "clr.do");
        chk("clr.cnt0", int'(bus.run_cnt), 0);
        chk("clr.hit0", int'(bus.hit), 0);
        step(0, 1, 1, 3, 0, "clr.next");
        chk("clr.cnt1", int'(bus.run_cnt), 1);

        // Asynchronous reset mid-run.
        for (int i = 0; i < 4; i++) step(0, 1, 1, 3, 0, "rst.run");
        chk("rst.cnt5", int'(bus.run_cnt), 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("rst.async");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 1, 3, 0, "rst.next");
        chk("rst.cnt1", int'(bus.run_cnt), 1);

        // Runs of 3, 6, 2: longest is 6.
        step(1, 0, 0, 0, 0, "max.clr");
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, "max.r3");
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, "max.r6");
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0, "max.r2");
`ifdef CONSEC_RUN_MAXLEN_EN
        chk("max.len", int'(bus.max_len), 6);
`else
        chk("max.len", int'(bus.max_len), 0);
`endif

        // Randomized stream with long-run bias.
        begin
            bit cur = 0;
            for (int i = 0; i < 3000; i++) begin
                bit c = ($urandom_range(0, 63) == 0);
                bit v = ($urandom_range(0, 3) != 0);
                int th = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15)
                                                      : $urandom_range(1, 6);
                int md = $urandom_range(0, 3);
                if ($urandom_range(0, 4) == 0) cur = ~cur;
                step(c, v, cur, th, md, "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/consec_run_detect.md
# consec_run_detect

Parametrised consecutive-value run detector: tracks the length of the current run of identical input bits and flags when it reaches a runtime-programmable threshold. It generalises the fixed four-in-a-row ones/zeros recogniser with a counter-based run length, a polarity mode select, a sample-valid qualifier, a synchronous clear and a one-shot detection pulse. It sits on serial bit streams, for example line-coding run-length checks and stuck-at detection, ahead of the status/interrupt logic.

## Interface
- CNT_W, 4: run counter width; threshold range 1..2^CNT_W-1
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear of run state and outputs
- in_valid  input  1  qualifies `in`; sample accepted only when high
- in  input  1  serial data bit
- thresh  input  CNT_W  run length required for detection; 0 disables detection
- mode  input  2  00 ones or zeros, 01 ones only, 10 zeros only, 11 detection off (counting continues)
- hit  output  1  level: current run meets threshold and polarity
- hit_pulse  output  1  single-cycle pulse on the accept that first makes the run reach thresh
- run_bit  output  1  value of the current run
- run_cnt  output  CNT_W  length of the current run, saturating
- max_len  output  CNT_W  longest run since reset/clear (see Configuration)

## Operation
- Two-state FSM: IDLE (no sample since reset/clr) and RUN.
- IDLE, accepted sample: run_bit <= in, run_cnt <= 1, go to RUN.
- RUN, accepted sample equal to run_bit: run_cnt <= run_cnt+1, saturating at 2^CNT_W-1.
- RUN, accepted sample differing: run_bit <= in, run_cnt <= 1; the run restarts.
- No accept (in_valid=0): all state and outputs hold; invalid cycles do not break a run.
- Polarity match: mode 00 always; 01 when the next run_bit=1; 10 when the next run_bit=0; 11 never.
- On every accept: hit <= (next_cnt >= thresh) && (thresh != 0) && polarity match. The comparison uses the next run_cnt and the next run_bit.
- On every accept: hit_pulse <= (next_cnt == thresh) && (run_cnt != thresh or the run restarted) && (thresh != 0) && polarity match. Otherwise hit_pulse <= 0 on every clock.
- thresh and mode are sampled only on accepts. A change takes effect at the next accepted sample, not retroactively.
- Saturation: once run_cnt = 2^CNT_W-1, further equal samples keep the count and keep hit. No second hit_pulse is generated.
- clr has priority over in_valid. The sample on that cycle is discarded, the FSM goes to IDLE, and run_cnt, run_bit, hit, hit_pulse and max_len are cleared to 0.

## Timing
- Reset values: state IDLE, run_cnt 0, run_bit 0, hit 0, hit_pulse 0, max_len 0.
- All outputs are registered and there are no combinational input-to-output paths.
- Latency: the sample that completes the run is accepted on edge k; hit and hit_pulse are high after edge k.
- Example, thresh=4 and mode=00 with a continuous stream 1,1,1,1: hit rises after the 4th edge.
- Asynchronous reset mid-run discards the run immediately. The first accepted sample after release starts a new run of length 1.
- in_valid may toggle on any cycle; there is no backpressure.

## Configuration
- CONSEC_RUN_MAXLEN_EN defined: max_len tracks the longest run since reset/clr. On each accept, max_len <= max(max_len, next_cnt); it saturates with run_cnt.
- CONSEC_RUN_MAXLEN_EN undefined: the max_len tracking logic is absent. The port remains and is tied to 0.

## Test plan
- CNT_W=4, thresh=4, mode=00, continuous 1,1,1,1,0,0,0,0: hit high after edges 4–4 and 8+; hit_pulse only after edges 4 and 8; run_cnt 1,2,3,4,1,2,3,4.
- thresh=3, mode=01, stream 0,0,0,0,1,1,1: no hit during the zeros; hit and hit_pulse after the 7th edge.
- thresh=3, stream 1,1, three in_valid=0 cycles, then 1: run_cnt holds at 2 during the gap; hit after the accept of the third 1.
- thresh=15, 20 consecutive 1s: run_cnt saturates at 15; exactly one hit_pulse; hit stays high.
- Run at run_cnt=5 with hit=1, then clr together with in_valid=1: all outputs 0 next cycle; the next accept gives run_cnt=1. Repeat with rst_n pulsed mid-run: same result.
- With CONSEC_RUN_MAXLEN_EN, runs of 3, 6, 2: max_len reads 6. Without the macro: max_len=0 throughout.
